simple_bus_arbiter: RTL and testbench
=====================================

SIMPLE_BUS_ARBITER -- requirements
Module: simple_bus_arbiter

Interface
REQ-001 Parameter NREQ SHALL be provided, default 4, meaning the number of requesters (2..8).
REQ-002 Parameter TIMEOUT SHALL be provided, default 16, meaning the maximum number of cycles spent in RD_WAIT before abort (2..255).
REQ-003 Port clock SHALL be an input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port req SHALL be an input, NREQ bits: per-requester transaction request, level.
REQ-006 Port req_read SHALL be an input, NREQ bits: per-requester direction (1 = read, 0 = write).
REQ-007 Port req_addr SHALL be an input, NREQ x 16 bits: per-requester 16-bit address.
REQ-008 Port req_wdata SHALL be an input, NREQ x 8 bits: per-requester write data.
REQ-009 Port gnt SHALL be an output, NREQ bits: one-hot grant, all-zero when no transaction is in progress.
REQ-010 Port done SHALL be an output, NREQ bits: one-hot, one-cycle completion pulse to the granted requester.
REQ-011 Port err SHALL be an output, 1 bit: timeout flag, valid only while any done bit is high.
REQ-012 Port rd_data SHALL be an output, 8 bits: captured read data.
REQ-013 Port start SHALL be an output, 1 bit: bus start strobe.
REQ-014 Port read SHALL be an output, 1 bit: bus direction strobe.
REQ-015 Ports address_out (8 bits) and address_oe (1 bit) SHALL be outputs: multiplexed address byte and its drive enable.
REQ-016 Ports data_in (8-bit input), data_out (8-bit output) and data_oe (1-bit output) SHALL carry the split bidirectional data bus.
REQ-017 Ports dv_in (1-bit input), dv_out (1-bit output) and dv_oe (1-bit output) SHALL carry the split bidirectional dataValid line.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR_HI, ADDR_LO, RD_WAIT, WR_DATA and DONE.
REQ-019 IDLE: if any req bit is high, the FSM SHALL select a winner round-robin, latch that requester's addr/read/wdata, set its gnt bit and go to ADDR_HI; otherwise it SHALL stay in IDLE.
REQ-020 Round-robin: search SHALL start at (last granted index + 1) mod NREQ; after reset, index 0 has highest priority.
REQ-021 ADDR_HI: start=1, address_oe=1, address_out=addr[15:8]; next state ADDR_LO.
REQ-022 ADDR_LO: address_oe=1, address_out=addr[7:0], read=latched read bit; next state RD_WAIT if read, else WR_DATA.
REQ-023 WR_DATA: data_oe=1, data_out=latched wdata, dv_oe=1, dv_out=1 for exactly one cycle; next state DONE with err=0.
REQ-024 RD_WAIT: when dv_in=1, rd_data SHALL load data_in and the FSM SHALL go to DONE with err=0.
REQ-025 RD_WAIT: a cycle counter SHALL clear on entry; if dv_in has not been seen after TIMEOUT cycles in RD_WAIT, the FSM SHALL go to DONE with err=1 and rd_data SHALL be left unchanged.
REQ-026 If dv_in=1 in the final timeout cycle, the data SHALL win: rd_data loads and err=0.
REQ-027 DONE: done[winner]=1 for one cycle, gnt remains held, err presented; next state IDLE, where gnt clears.
REQ-028 req SHALL be sampled only in IDLE; the requester drops req on done, and a req still high in the following IDLE cycle SHALL start a new transaction.
REQ-029 Latency SHALL be: write occupies 5 cycles (IDLE through DONE); read occupies 4 + N cycles, where N ≥ 1 is the number of cycles spent in RD_WAIT.
REQ-030 In all states not listed above, start, read, address_oe, data_oe and dv_oe SHALL be 0; dv_oe SHALL be 0 in RD_WAIT.
REQ-031 Changes on req, req_addr or req_wdata after grant SHALL NOT affect the transaction in progress.

Reset
REQ-032 While reset is high at a clock edge: state SHALL become IDLE; gnt, done, err, start, read and all *_oe SHALL be 0; rd_data, address_out, data_out and dv_out SHALL be 0; the round-robin pointer SHALL be reset so index 0 is searched first; the timeout counter SHALL be 0.
REQ-033 Reset mid-transaction SHALL abort the transaction with no done pulse, and all bus enables SHALL be released on the same edge.

Structure
REQ-034 The state enum and the default NREQ and TIMEOUT constants SHALL live in package simple_bus_pkg.
REQ-035 Round-robin selection and the last-grant pointer SHALL be one sub-module, rr_arbiter (inputs req, advance; output one-hot grant).

Verification
REQ-036 Write: after reset, req[0]=1, read=0, addr=16'hA55A, wdata=8'h3C. Required: start with address_out=8'hA5, then address_out=8'h5A with read=0, then data_out=8'h3C with dv_out=1, then done[0] 4 cycles after grant cycle, err=0.
REQ-037 Read: req[2]=1, read=1, addr=16'h1234, slave asserts dv_in with data_in=8'hE7 on the third RD_WAIT cycle. Required: rd_data=8'hE7 and done[2] the next cycle, err=0.
REQ-038 Timeout: read with dv_in held at 0 and TIMEOUT=16. Required: done with err=1 exactly 16 RD_WAIT cycles after entry, and rd_data unchanged.
REQ-039 Fairness: req=4'b1111 held continuously. Required: grant order 0,1,2,3,0, and no requester is granted twice before all the others.
REQ-040 Reset mid-read: assert reset during RD_WAIT. Required: next cycle gnt=0, all oe=0, no done pulse; the next req=4'b1000 is granted to index 3.
REQ-041 Boundary: dv_in=1 in the 16th RD_WAIT cycle. Required: err=0 and rd_data loaded.

Source files
------------

// File: rtl/simple_bus_pkg.sv
// Shared types and defaults for the simple bus arbiter: FSM states,
// latched transaction record and the registered bus-drive bundle.
package simple_bus_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    RD_WAIT,
    WR_DATA,
    DONE
  } busState_e;

  // Transaction captured from the winning requester at grant time
  typedef struct packed {
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xact_t;

  // Everything the arbiter drives onto the shared bus in one cycle
  typedef struct packed {
    logic              start;
    logic              read;
    logic              addrOe;
    logic [DATA_W-1:0] addrOut;
    logic              dataOe;
    logic [DATA_W-1:0] dataOut;
    logic              dvOe;
    logic              dvOut;
  } busOut_t;

endpackage

// File: rtl/simple_bus_arbiter_if.sv
// Shared byte-wide bus between the arbiter (master) and the slave; the
// bidirectional data and dataValid lines are split into in/out/oe.
interface simple_bus_arbiter_if;
  import simple_bus_pkg::*;

  logic              start;
  logic              read;
  logic [DATA_W-1:0] address_out;
  logic              address_oe;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              dv_in;
  logic              dv_out;
  logic              dv_oe;

  modport master (
    output start, read, address_out, address_oe, data_out, data_oe, dv_out, dv_oe,
    input  data_in, dv_in
  );

  modport slave (
    input  start, read, address_out, address_oe, data_out, data_oe, dv_out, dv_oe,
    output data_in, dv_in
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant among active requests, searching from
// the slot after the last winner; the pointer moves only when advance is high.
module rr_arbiter
  import simple_bus_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0] lastIdx;
  logic [IDX_W-1:0] winIdx;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Rotating priority search starting just after the previous winner
  always_comb begin
    grant  = '0;
    winIdx = lastIdx;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDX_W'((32'(lastIdx) + off) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winIdx = cand;
      end
    end
    if (found) grant[winIdx] = 1'b1;
  end

  // Reset to the top slot so index 0 is searched first
  always_ff @(posedge clock) begin
    if (reset) lastIdx <= IDX_W'(NREQ - 1);
    else if (advance && found) lastIdx <= winIdx;
  end

endmodule

// File: rtl/simple_bus_arbiter.sv
// Multi-requester front end for a byte-wide multiplexed bus: round-robin
// grant, address hi/lo phases, single-cycle write data, timed read wait.
module simple_bus_arbiter
  import simple_bus_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              req_read,
  input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              done,
  output logic                         err,
  output logic [DATA_W-1:0]            rd_data,
  simple_bus_arbiter_if.master         bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  busState_e        state;
  busState_e        nextState;
  logic             timeoutHit;
  logic [CNT_W-1:0] waitCnt;
  logic [NREQ-1:0]  grant;
  logic             advance;
  xact_t            xact;
  xact_t            xactNext;
  busOut_t          busNext;
  busOut_t          busReg;

  assign advance = (state == IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  // State register; bus drives are registered from the next-state decode
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busReg <= '0;
    end else begin
      state  <= nextState;
      busReg <= busNext;
    end
  end

  // Next-state decode; read data arriving in the last wait cycle beats timeout
  always_comb begin
    nextState  = state;
    timeoutHit = 1'b0;
    case (state)
      IDLE:    if (|req) nextState = ADDR_HI;
      ADDR_HI: nextState = ADDR_LO;
      ADDR_LO: nextState = xact.read ? RD_WAIT : WR_DATA;
      RD_WAIT: begin
        if (bus.dv_in) begin
          nextState = DONE;
        end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
          nextState  = DONE;
          timeoutHit = 1'b1;
        end
      end
      WR_DATA: nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus drive values for the state about to be entered
  always_comb begin
    busNext = '0;
    case (nextState)
      ADDR_HI: begin
        busNext.start   = 1'b1;
        busNext.addrOe  = 1'b1;
        busNext.addrOut = xactNext.addr[ADDR_W-1:DATA_W];
      end
      ADDR_LO: begin
        busNext.addrOe  = 1'b1;
        busNext.addrOut = xactNext.addr[DATA_W-1:0];
        busNext.read    = xactNext.read;
      end
      WR_DATA: begin
        busNext.dataOe  = 1'b1;
        busNext.dataOut = xactNext.wdata;
        busNext.dvOe    = 1'b1;
        busNext.dvOut   = 1'b1;
      end
      default: busNext = '0;
    endcase
  end

  // Capture the winner's request only in IDLE so later input changes are ignored
  always_comb begin
    xactNext = xact;
    if (state == IDLE) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          xactNext.read  = req_read[i];
          xactNext.addr  = req_addr[i];
          xactNext.wdata = req_wdata[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xact    <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rd_data <= '0;
      waitCnt <= '0;
    end else begin
      xact <= xactNext;
      if (state == IDLE && nextState == ADDR_HI) gnt <= grant;
      else if (state == DONE)                    gnt <= '0;
      done <= (nextState == DONE) ? gnt : '0;
      err  <= timeoutHit;
      if (state == RD_WAIT && bus.dv_in) rd_data <= bus.data_in;
      waitCnt <= (state == RD_WAIT && nextState == RD_WAIT) ? waitCnt + CNT_W'(1) : '0;
    end
  end

  assign bus.start       = busReg.start;
  assign bus.read        = busReg.read;
  assign bus.address_oe  = busReg.addrOe;
  assign bus.address_out = busReg.addrOut;
  assign bus.data_oe     = busReg.dataOe;
  assign bus.data_out    = busReg.dataOut;
  assign bus.dv_oe       = busReg.dvOe;
  assign bus.dv_out      = busReg.dvOut;

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Directed bench for simple_bus_arbiter: a table of single transactions with
// hand-computed results, then fairness and reset-abort sequences.
module tb_simple_bus_arbiter;

  logic             clock;
  logic             reset;
  logic [3:0]       req;
  logic [3:0]       req_read;
  logic [3:0][15:0] req_addr;
  logic [3:0][7:0]  req_wdata;
  logic [3:0]       gnt;
  logic [3:0]       done;
  logic             err;
  logic [7:0]       rd_data;

  simple_bus_arbiter_if bus();

  simple_bus_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_read  (req_read),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rd_data   (rd_data),
    .bus       (bus)
  );

  typedef struct {
    logic [3:0]  mask;
    logic        isRead;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          dvCycle;
    logic [7:0]  din;
    int          expIdx;
    logic [7:0]  expHi;
    logic [7:0]  expLo;
    int          expWait;
    logic        expErr;
    logic [7:0]  expRd;
  } vec_t;

  vec_t vecs [9];
  vec_t tail;
  int   checks;
  int   errors;
  int   order [$];
  int   expOrd [5] = '{0, 1, 2, 3, 0};
  logic [3:0] prevG;
  logic       doneSeen;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int ohIdx(input logic [3:0] v);
    int r;
    r = -1;
    if ($onehot(v))
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic doReset();
    reset = 1'b1;
    req = '0;
    bus.dv_in = 1'b0;
    bus.data_in = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One full transaction: drive at IDLE, check every phase through DONE and back to IDLE
  task automatic runXact(input vec_t v, input string tag);
    logic [3:0] oh;
    oh = 4'(1 << v.expIdx);
    bus.dv_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_read[i]  = ~v.isRead;
      req_addr[i]  = 16'hDEAD ^ 16'(i);
      req_wdata[i] = 8'hEE;
    end
    req_read[v.expIdx]  = v.isRead;
    req_addr[v.expIdx]  = v.addr;
    req_wdata[v.expIdx] = v.wdata;
    req = v.mask;
    step();
    chk({tag, ".gnt"}, 32'(gnt), 32'(oh));
    chk({tag, ".addr_hi"}, 32'({bus.start, bus.address_oe, bus.read, bus.data_oe, bus.dv_oe, bus.address_out}),
        32'({5'b11000, v.expHi}));
    req_addr[v.expIdx]  = ~v.addr;
    req_wdata[v.expIdx] = ~v.wdata;
    req_read[v.expIdx]  = ~v.isRead;
    step();
    chk({tag, ".addr_lo"}, 32'({bus.start, bus.address_oe, bus.read, bus.data_oe, bus.dv_oe, bus.address_out}),
        32'({2'b01, v.isRead, 2'b00, v.expLo}));
    step();
    if (!v.isRead) begin
      chk({tag, ".wr_data"}, 32'({bus.start, bus.address_oe, bus.read, bus.data_oe, bus.dv_oe, bus.dv_out, bus.data_out, done}),
          32'({6'b000111, v.wdata, 4'b0000}));
      step();
    end else begin
      for (int k = 1; k <= v.expWait; k++) begin
        chk($sformatf("%s.wait%0d", tag, k),
            32'({bus.start, bus.address_oe, bus.read, bus.data_oe, bus.dv_oe, done}), 32'd0);
        bus.dv_in   = (k == v.dvCycle);
        bus.data_in = (k == v.dvCycle) ? v.din : 8'h55;
        step();
      end
      bus.dv_in = 1'b0;
    end
    chk({tag, ".done"}, 32'({done, gnt, err}), 32'({oh, oh, v.expErr}));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(v.expRd));
    req = '0;
    step();
    chk({tag, ".idle"}, 32'({gnt, done, err, bus.start, bus.address_oe}), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    req_read = '0;
    req_addr = '0;
    req_wdata = '0;
    //            mask     rd    addr      wdata  dvC din    idx hi     lo     wait err   rd
    vecs[0] = '{4'b0001, 1'b0, 16'hA55A, 8'h3C, 0,  8'h00, 0, 8'hA5, 8'h5A, 0,  1'b0, 8'h00};
    vecs[1] = '{4'b0100, 1'b1, 16'h1234, 8'h00, 3,  8'hE7, 2, 8'h12, 8'h34, 3,  1'b0, 8'hE7};
    vecs[2] = '{4'b0010, 1'b1, 16'hBEEF, 8'h00, 0,  8'h00, 1, 8'hBE, 8'hEF, 16, 1'b1, 8'hE7};
    vecs[3] = '{4'b1000, 1'b1, 16'h0F0F, 8'h00, 16, 8'h5A, 3, 8'h0F, 8'h0F, 16, 1'b0, 8'h5A};
    vecs[4] = '{4'b1111, 1'b0, 16'h00FF, 8'hC3, 0,  8'h00, 0, 8'h00, 8'hFF, 0,  1'b0, 8'h5A};
    vecs[5] = '{4'b0110, 1'b1, 16'h8001, 8'h00, 1,  8'h81, 1, 8'h80, 8'h01, 1,  1'b0, 8'h81};
    vecs[6] = '{4'b0101, 1'b0, 16'hFFFF, 8'h00, 0,  8'h00, 2, 8'hFF, 8'hFF, 0,  1'b0, 8'h81};
    vecs[7] = '{4'b0011, 1'b1, 16'h7E80, 8'h00, 2,  8'h00, 0, 8'h7E, 8'h80, 2,  1'b0, 8'h00};
    vecs[8] = '{4'b1010, 1'b0, 16'h4321, 8'h99, 0,  8'h00, 1, 8'h43, 8'h21, 0,  1'b0, 8'h00};
    tail    = '{4'b1000, 1'b0, 16'h2468, 8'h7B, 0,  8'h00, 3, 8'h24, 8'h68, 0,  1'b0, 8'h00};

    doReset();
    chk("reset.ctrl", 32'({gnt, done, err, rd_data, bus.start, bus.read, bus.address_oe, bus.data_oe, bus.dv_oe}), 32'd0);
    chk("reset.bus", 32'({bus.address_out, bus.data_out, bus.dv_out}), 32'd0);
    step();
    step();
    chk("idle.noreq", 32'({gnt, done, bus.start, bus.address_oe}), 32'd0);

    for (int i = 0; i < 9; i++) runXact(vecs[i], $sformatf("v%0d", i));

    // Fairness: all four requesting continuously from a fresh reset
    doReset();
    for (int i = 0; i < 4; i++) begin
      req_read[i]  = 1'b0;
      req_addr[i]  = 16'h1000 + 16'(i);
      req_wdata[i] = 8'(i);
    end
    req = 4'b1111;
    prevG = '0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      step();
      if (gnt != 4'b0000 && prevG == 4'b0000) order.push_back(ohIdx(gnt));
      prevG = gnt;
    end
    chk("fair.count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size() && i < 5; i++)
      chk($sformatf("fair.grant%0d", i), 32'(order[i]), 32'(expOrd[i]));
    req = '0;
    for (int c = 0; c < 6; c++) step();

    // Reset in the middle of a read wait aborts with no done pulse
    doReset();
    req_read[2] = 1'b1;
    req_addr[2] = 16'h1234;
    req = 4'b0100;
    step();
    step();
    step();
    step();
    chk("rst.pre_gnt", 32'({gnt, bus.dv_oe, bus.data_oe}), 32'({4'b0100, 2'b00}));
    reset = 1'b1;
    step();
    chk("rst.ctrl", 32'({gnt, done, err, rd_data, bus.start, bus.read, bus.address_oe, bus.data_oe, bus.dv_oe}), 32'd0);
    chk("rst.bus", 32'({bus.address_out, bus.data_out, bus.dv_out}), 32'd0);
    reset = 1'b0;
    req = '0;
    doneSeen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      doneSeen = doneSeen | (|done);
    end
    chk("rst.no_done", 32'(doneSeen), 32'd0);
    runXact(tail, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
